filtro_secuenciador: RTL and testbench

- Control FSM that sequences one output sample of the fixed-point filter datapath: delay-line shift, accumulator clear, TAPS multiply-accumulate steps, then scaling/saturation of the 2N-bit accumulator into the N-bit result.
- Drives the load enables (bandera-style) of the datapath registers, which capture on the falling edge. This block runs on the rising edge, so every enable is stable across the falling edge of its cycle.
- Sits between the sample-ready strobe (ADC/input side) and the output register feeding the DAC.

---
 rtl/filtro_secuenciador.sv | 129 ++++++++++++
 tb/tb_filtro_secuenciador.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/filtro_secuenciador.sv
// Control sequencer for one output sample of the fixed-point filter datapath:
// shift/clear, TAPS MAC steps, then scale and saturate the accumulator into yk.
module filtro_secuenciador #(
    parameter int N    = 25,
    parameter int TAPS = 3,
    parameter int FRAC = 10,
    parameter int IW   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  muestra_lista,
    input  logic                  clr_err,
    input  logic signed [2*N-1:0] acc_in,
    output logic                  bandera_desp,
    output logic                  clr_acc,
    output logic                  en_mac,
    output logic [IW-1:0]         sel_coef,
    output logic                  bandera_fk,
    output logic signed [N-1:0]   yk,
    output logic                  dato_valido,
    output logic                  ocupado,
    output logic                  overrun,
    output logic                  sat
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [IW-1:0]         LAST_TAP = IW'(TAPS - 1);
    // N-bit signed limits, sign-extended to accumulator width for comparison.
    localparam logic signed [2*N-1:0] Y_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] Y_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    state_t               state_q, state_d;
    logic [IW-1:0]        k_q, k_d;
    logic signed [N-1:0]  yk_q, yk_d;
    logic                 overrun_q, overrun_d;
    logic                 sat_q, sat_d;

    logic signed [2*N-1:0] acc_shift;
    logic                  sat_hi, sat_lo;
    logic                  en_curso;

    assign acc_shift = acc_in >>> FRAC;
    assign sat_hi    = acc_shift > Y_MAX;
    assign sat_lo    = acc_shift < Y_MIN;
    assign en_curso  = (state_q == S_CLEAR) || (state_q == S_MAC) || (state_q == S_LOAD);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE:  if (muestra_lista) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_MAC;
                k_d     = '0;
            end
            S_MAC: begin
                if (k_q == LAST_TAP) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_DONE:  state_d = muestra_lista ? S_CLEAR : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Result register and sticky flags; a set in the same cycle wins over clr_err.
    always_comb begin
        yk_d      = yk_q;
        sat_d     = sat_q;
        overrun_d = overrun_q;
        if (clr_err) begin
            sat_d     = 1'b0;
            overrun_d = 1'b0;
        end
        if (state_q == S_LOAD) begin
            if (sat_hi) begin
                yk_d  = Y_MAX[N-1:0];
                sat_d = 1'b1;
            end else if (sat_lo) begin
                yk_d  = Y_MIN[N-1:0];
                sat_d = 1'b1;
            end else begin
                yk_d = acc_shift[N-1:0];
            end
        end
        if (muestra_lista && en_curso) overrun_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            yk_q      <= '0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            yk_q      <= yk_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
        end
    end

    assign bandera_desp = (state_q == S_CLEAR);
    assign clr_acc      = (state_q == S_CLEAR);
    assign en_mac       = (state_q == S_MAC);
    assign sel_coef     = (state_q == S_MAC) ? k_q : '0;
    assign bandera_fk   = (state_q == S_LOAD);
    assign dato_valido  = (state_q == S_DONE);
    assign ocupado      = (state_q != S_IDLE);
    assign yk           = yk_q;
    assign overrun      = overrun_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Directed self-checking bench for filtro_secuenciador (N=25, TAPS=3, FRAC=10).
module tb_filtro_secuenciador;

    localparam int N    = 25;
    localparam int TAPS = 3;
    localparam int FRAC = 10;
    localparam int IW   = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  muestra_lista;
    logic                  clr_err;
    logic signed [2*N-1:0] acc_in;
    logic                  bandera_desp, clr_acc, en_mac, bandera_fk;
    logic [IW-1:0]         sel_coef;
    logic signed [N-1:0]   yk;
    logic                  dato_valido, ocupado, overrun, sat;

    int checks = 0;
    int errors = 0;

    filtro_secuenciador #(.N(N), .TAPS(TAPS), .FRAC(FRAC), .IW(IW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .muestra_lista (muestra_lista),
        .clr_err       (clr_err),
        .acc_in        (acc_in),
        .bandera_desp  (bandera_desp),
        .clr_acc       (clr_acc),
        .en_mac        (en_mac),
        .sel_coef      (sel_coef),
        .bandera_fk    (bandera_fk),
        .yk            (yk),
        .dato_valido   (dato_valido),
        .ocupado       (ocupado),
        .overrun       (overrun),
        .sat           (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic desp;
        logic clr;
        logic mac;
        int   sel;
        logic fk;
        logic dv;
        logic ocup;
    } lat_vec_t;

    typedef struct {
        longint acc;
        longint yk_exp;
        logic   sat_exp;
    } scale_vec_t;

    lat_vec_t   lat_tab[7];
    scale_vec_t scale_tab[5];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_clr_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Pulses muestra_lista for one cycle and returns the cycle index in which
    // dato_valido is seen (-1 on timeout). Returns at the negedge of DONE.
    task automatic run_sample(input longint acc, output int lat);
        acc_in        = acc[2*N-1:0];
        muestra_lista = 1'b1;
        lat           = -1;
        @(negedge clk);
        muestra_lista = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (dato_valido) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int dv_cnt;

        // cycle-by-cycle expectations after a single strobe at E0 (TAPS=3)
        lat_tab[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        lat_tab[1] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1};
        lat_tab[2] = '{1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        lat_tab[3] = '{1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1};
        lat_tab[4] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1};
        lat_tab[5] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1};
        lat_tab[6] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};

        scale_tab[0] = '{64'sd5120,                  64'sd5,         1'b0};
        scale_tab[1] = '{-64'sd3,                    -64'sd1,        1'b0};
        scale_tab[2] = '{-64'sd5120,                 -64'sd5,        1'b0};
        scale_tab[3] = '{64'sd1099511627776,         64'sd16777215,  1'b1};
        scale_tab[4] = '{-64'sd1099511627776,        -64'sd16777216, 1'b1};

        reset_n       = 1'b0;
        muestra_lista = 1'b0;
        clr_err       = 1'b0;
        acc_in        = '0;
        repeat (2) @(negedge clk);

        check("rst_ocupado", ocupado, 0);
        check("rst_strobes", {bandera_desp, clr_acc, en_mac, bandera_fk, dato_valido}, 0);
        check("rst_sel", sel_coef, 0);
        check("rst_yk", yk, 0);
        check("rst_flags", {overrun, sat}, 0);

        reset_n = 1'b1;
        @(negedge clk);

        // latency / strobe sequence
        acc_in        = 50'sd5120;
        muestra_lista = 1'b1;
        @(negedge clk);
        muestra_lista = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("lat%0d_desp", c + 1), bandera_desp, lat_tab[c].desp);
            check($sformatf("lat%0d_clr", c + 1),  clr_acc,      lat_tab[c].clr);
            check($sformatf("lat%0d_mac", c + 1),  en_mac,       lat_tab[c].mac);
            check($sformatf("lat%0d_sel", c + 1),  sel_coef,     lat_tab[c].sel);
            check($sformatf("lat%0d_fk", c + 1),   bandera_fk,   lat_tab[c].fk);
            check($sformatf("lat%0d_dv", c + 1),   dato_valido,  lat_tab[c].dv);
            check($sformatf("lat%0d_ocup", c + 1), ocupado,      lat_tab[c].ocup);
            @(negedge clk);
        end

        // scaling and saturation
        for (int i = 0; i < 5; i++) begin
            pulse_clr_err();
            check($sformatf("scale%0d_sat_cleared", i), sat, 0);
            run_sample(scale_tab[i].acc, lat);
            check($sformatf("scale%0d_latency", i), lat, TAPS + 3);
            check($sformatf("scale%0d_yk", i), longint'(yk), scale_tab[i].yk_exp);
            check($sformatf("scale%0d_sat", i), sat, scale_tab[i].sat_exp);
            @(negedge clk);
            check($sformatf("scale%0d_yk_hold", i), longint'(yk), scale_tab[i].yk_exp);
        end
        pulse_clr_err();
        check("clr_err_sat", sat, 0);

        // reset in the middle of MAC; sat set beforehand to see it cleared
        run_sample(64'sd1099511627776, lat);
        @(negedge clk);
        acc_in        = 50'sd5120;
        muestra_lista = 1'b1;
        @(negedge clk);
        muestra_lista = 1'b0;
        @(negedge clk);
        check("pre_rst_in_mac", en_mac, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_strobes", {bandera_desp, clr_acc, en_mac, bandera_fk, dato_valido}, 0);
        check("arst_ocupado", ocupado, 0);
        check("arst_yk", yk, 0);
        check("arst_flags", {overrun, sat}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dv_cnt  = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dato_valido) dv_cnt++;
        end
        check("arst_no_dv", dv_cnt, 0);
        run_sample(64'sd5120, lat);
        check("post_rst_latency", lat, TAPS + 3);
        check("post_rst_yk", longint'(yk), 5);
        @(negedge clk);

        // overrun: second strobe during MAC is dropped
        acc_in        = 50'sd5120;
        muestra_lista = 1'b1;
        dv_cnt        = 0;
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            if (dato_valido) dv_cnt++;
            muestra_lista = (c == 3);
            @(negedge clk);
        end
        check("ovr_flag", overrun, 1);
        check("ovr_one_dv", dv_cnt, 1);
        check("ovr_idle", ocupado, 0);

        // back-to-back with the strobe held high
        pulse_clr_err();
        check("b2b_ovr_cleared", overrun, 0);
        muestra_lista = 1'b1;
        lat           = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dato_valido) begin
                lat = c;
                break;
            end
        end
        check("b2b_first_latency", lat, TAPS + 3);
        @(negedge clk);
        muestra_lista = 1'b0;
        check("b2b_clear_next", {bandera_desp, clr_acc, ocupado}, 3'b111);
        check("b2b_ovr", overrun, 1);
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            if (dato_valido) begin
                lat = c;
                break;
            end
        end
        check("b2b_second_latency", lat, TAPS + 3);
        @(negedge clk);
        check("b2b_idle", ocupado, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
